// File: rtl/ccd_pkg.sv
// Shared types and sizing for the CCD line controller.
package ccd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SI    = 2'd1,
    ST_READ  = 2'd2,
    ST_INTEG = 2'd3
  } ccd_state_e;

  // Index must hold PIXELS itself, hence the +1.
  function automatic int pix_w(input int pixels);
    return $clog2(pixels + 1);
  endfunction

  localparam int PIXELS_DEF = 128;
  localparam int PIX_W_DEF  = pix_w(PIXELS_DEF);

endpackage

// File: rtl/ccd_tick_div.sv
// Half-period divider: down-counter that marks the last cycle of each ccdclk half.
module ccd_tick_div #(
  parameter int CLK_DIV = 25
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (clear || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // pre_tick lets the owner register a strobe that lands on the tick cycle.
  assign tick     = !clear && (cnt == '0);
  assign pre_tick = !clear && (cnt == CNT_W'(1));

endmodule

// File: rtl/ccd_line_ctrl.sv
// CCD line sequencer: SI pulse, PIXELS readout periods, exposure wait, line bookkeeping.
//   state    | meaning
//   ST_IDLE  | outputs quiet, waiting for enable & fifo_empty & !tx_busy
//   ST_SI    | one ccdclk period with si high
//   ST_READ  | PIXELS ccdclk periods, ADC sample + FIFO write in each low half
//   ST_INTEG | exposure wait of the latched integ_cycles
module ccd_line_ctrl
  import ccd_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int PIXELS  = PIXELS_DEF,
  parameter int INTEG_W = 24
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               enable,
  input  logic [INTEG_W-1:0] integ_cycles,
  input  logic               fifo_full,
  input  logic               fifo_empty,
  input  logic               tx_busy,
  output logic               ccdclk,
  output logic               si,
  output logic               ad_clk,
  output logic               fifo_wr,
  output logic               line_done,
  output logic [15:0]        line_cnt,
  output logic               overrun
);

  localparam int PIX_W = pix_w(PIXELS);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXELS - 1);

  ccd_state_e         state, state_nxt;
  logic               half, half_nxt;
  logic [PIX_W-1:0]   pix_idx, pix_idx_nxt;
  logic [INTEG_W-1:0] integ_lat, integ_lat_nxt;
  logic [INTEG_W-1:0] integ_cnt, integ_cnt_nxt;
  logic [15:0]        line_cnt_q, line_cnt_d;

  logic start, line_end, wr_due, div_clear, tick, pre_tick;
  logic ccdclk_d, si_d, ad_clk_d, fifo_wr_d, line_done_d, overrun_d;

  assign div_clear = (state == ST_IDLE);
  // line_done blocks the start so a finished line always sees one plain IDLE cycle.
  assign start = enable && fifo_empty && !tx_busy && !line_done;
  assign line_cnt = line_cnt_q;

  ccd_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .clear    (div_clear),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      half       <= 1'b0;
      pix_idx    <= '0;
      integ_lat  <= '0;
      integ_cnt  <= '0;
      line_cnt_q <= '0;
      ccdclk     <= 1'b0;
      si         <= 1'b0;
      ad_clk     <= 1'b0;
      fifo_wr    <= 1'b0;
      line_done  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      half       <= half_nxt;
      pix_idx    <= pix_idx_nxt;
      integ_lat  <= integ_lat_nxt;
      integ_cnt  <= integ_cnt_nxt;
      line_cnt_q <= line_cnt_d;
      ccdclk     <= ccdclk_d;
      si         <= si_d;
      ad_clk     <= ad_clk_d;
      fifo_wr    <= fifo_wr_d;
      line_done  <= line_done_d;
      overrun    <= overrun_d;
    end
  end

  always_comb begin
    state_nxt     = state;
    half_nxt      = half;
    pix_idx_nxt   = pix_idx;
    integ_lat_nxt = integ_lat;
    integ_cnt_nxt = integ_cnt;
    line_end      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt     = ST_SI;
          half_nxt      = 1'b0;
          pix_idx_nxt   = '0;
          integ_lat_nxt = integ_cycles;
        end
      end
      ST_SI: begin
        if (tick) begin
          if (!half) begin
            half_nxt = 1'b1;
          end else begin
            state_nxt = ST_READ;
            half_nxt  = 1'b0;
          end
        end
      end
      ST_READ: begin
        if (tick) begin
          if (!half) begin
            half_nxt = 1'b1;
          end else if (pix_idx == LAST_PIX) begin
            half_nxt = 1'b0;
            if (integ_lat == '0) begin
              state_nxt = ST_IDLE;
              line_end  = 1'b1;
            end else begin
              state_nxt     = ST_INTEG;
              integ_cnt_nxt = integ_lat - INTEG_W'(1);
            end
          end else begin
            half_nxt    = 1'b0;
            pix_idx_nxt = pix_idx + PIX_W'(1);
          end
        end
      end
      ST_INTEG: begin
        if (integ_cnt == '0) begin
          state_nxt = ST_IDLE;
          line_end  = 1'b1;
        end else begin
          integ_cnt_nxt = integ_cnt - INTEG_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ccdclk_d    = ((state_nxt == ST_SI) || (state_nxt == ST_READ)) && half_nxt;
    si_d        = (state_nxt == ST_SI);
    ad_clk_d    = (state_nxt == ST_READ) && !half_nxt;
    // Write is decided one cycle early so the registered strobe hits the last low cycle.
    wr_due      = (state == ST_READ) && !half && pre_tick;
    fifo_wr_d   = wr_due && !fifo_full;
    overrun_d   = overrun || (wr_due && fifo_full);
    line_done_d = line_end;
    line_cnt_d  = line_end ? (line_cnt_q + 16'd1) : line_cnt_q;
  end

endmodule

// File: tb/tb_ccd_line_ctrl.sv
// Directed bench for ccd_line_ctrl with CLK_DIV=2, PIXELS=128.
module tb_ccd_line_ctrl;
  import ccd_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int PIXELS  = 128;
  localparam int INTEG_W = 24;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic               enable = 1'b0;
  logic [INTEG_W-1:0] integ_cycles = '0;
  logic               fifo_full = 1'b0;
  logic               fifo_empty = 1'b1;
  logic               tx_busy = 1'b0;
  logic               ccdclk, si, ad_clk, fifo_wr, line_done, overrun;
  logic [15:0]        line_cnt;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  logic mon_clr = 1'b0;
  logic si_q = 1'b0;
  logic ccdclk_q = 1'b0;
  int si_cnt, rise_cnt, first_rise_cyc, wr_cnt, first_wr_cyc, last_wr_cyc;
  int done_cyc, done_cnt, ad_bad;

  ccd_line_ctrl #(
    .CLK_DIV (CLK_DIV),
    .PIXELS  (PIXELS),
    .INTEG_W (INTEG_W)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .enable       (enable),
    .integ_cycles (integ_cycles),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .tx_busy      (tx_busy),
    .ccdclk       (ccdclk),
    .si           (si),
    .ad_clk       (ad_clk),
    .fifo_wr      (fifo_wr),
    .line_done    (line_done),
    .line_cnt     (line_cnt),
    .overrun      (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Cycle n is the one whose values appear just after the n-th rising edge.
  always @(negedge sys_clk) begin
    if (mon_clr) begin
      si_cnt = 0; rise_cnt = 0; first_rise_cyc = -1; wr_cnt = 0;
      first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1; done_cnt = 0; ad_bad = 0;
    end else begin
      if (si) si_cnt++;
      if (ccdclk && !ccdclk_q) begin
        rise_cnt++;
        if (first_rise_cyc < 0) first_rise_cyc = cyc;
      end
      if (fifo_wr) begin
        wr_cnt++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
      end
      if (line_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if ((ad_clk && ccdclk) || (fifo_wr && !ad_clk) || (si && ad_clk)) ad_bad++;
    end
    si_q = si;
    ccdclk_q = ccdclk;
  end

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic wait_si(input int budget, input string tag);
    int n = 0;
    while (!si && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_si_start"}, 32'(si), 1);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, fall, d1, busy_leak;

    sys_rst = 1'b1;
    clear_mon();
    repeat (3) step();
    chk("reset_outputs", 32'({ccdclk, si, ad_clk, fifo_wr, line_done, overrun}), 0);
    chk("reset_line_cnt", 32'(line_cnt), 0);
    chk("reset_state", 32'(dut.state), 32'(ST_IDLE));

    // Single line, start gated by tx_busy, inputs disturbed mid-line.
    sys_rst = 1'b0;
    integ_cycles = 24'd10;
    enable = 1'b1;
    fifo_empty = 1'b1;
    tx_busy = 1'b1;
    busy_leak = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (si) busy_leak++;
    end
    chk("busy_gate", busy_leak, 0);
    tx_busy = 1'b0;
    fall = cyc;
    wait_si(10, "line1");
    t0 = cyc;
    chk("start_latency", t0, fall + 1);
    step();
    enable = 1'b0;
    integ_cycles = 24'd3;
    fifo_empty = 1'b0;
    tx_busy = 1'b1;
    wait_done(1, 2000, "line1");
    chk("si_cycles", si_cnt, 4);
    chk("first_ccdclk_rise", first_rise_cyc, t0 + 2);
    chk("ccdclk_rises", rise_cnt, PIXELS + 1);
    chk("wr_count", wr_cnt, PIXELS);
    chk("first_wr", first_wr_cyc, t0 + 5);
    chk("last_wr", last_wr_cyc, t0 + 513);
    chk("line_done_time", done_cyc, t0 + 526);
    chk("line_cnt_1", 32'(line_cnt), 1);
    chk("no_overrun", 32'(overrun), 0);
    chk("strobe_shape", ad_bad, 0);
    fifo_empty = 1'b1;
    tx_busy = 1'b0;
    repeat (30) step();
    chk("idle_after_disable", si_cnt, 4);
    chk("idle_state", 32'(dut.state), 32'(ST_IDLE));

    // Back-to-back lines with zero exposure.
    clear_mon();
    integ_cycles = '0;
    enable = 1'b1;
    wait_si(10, "b2b");
    t0 = cyc;
    wait_done(1, 2000, "b2b_first");
    d1 = done_cyc;
    chk("integ0_done_time", d1, t0 + 516);
    wait_si(10, "b2b_second");
    chk("b2b_gap", cyc, d1 + 2);
    enable = 1'b0;
    wait_done(2, 2000, "b2b_second");
    chk("b2b_wr_count", wr_cnt, 2 * PIXELS);
    chk("line_cnt_3", 32'(line_cnt), 3);

    // FIFO full across pixels 10..19.
    repeat (5) step();
    clear_mon();
    integ_cycles = 24'd10;
    enable = 1'b1;
    wait_si(10, "full");
    t0 = cyc;
    enable = 1'b0;
    repeat (44) step();
    fifo_full = 1'b1;
    repeat (40) step();
    fifo_full = 1'b0;
    chk("overrun_set", 32'(overrun), 1);
    wait_done(1, 2000, "full");
    chk("full_wr_count", wr_cnt, 118);
    chk("full_done_time", done_cyc, t0 + 526);
    chk("full_rises", rise_cnt, PIXELS + 1);
    repeat (10) step();
    chk("overrun_sticky", 32'(overrun), 1);

    // Reset in the middle of a line.
    clear_mon();
    enable = 1'b1;
    wait_si(10, "rst");
    t0 = cyc;
    enable = 1'b0;
    repeat (200) step();
    sys_rst = 1'b1;
    step();
    chk("midrst_time", cyc, t0 + 201);
    chk("midrst_outputs", 32'({ccdclk, si, ad_clk, fifo_wr, line_done, overrun}), 0);
    chk("midrst_line_cnt", 32'(line_cnt), 0);
    chk("midrst_state", 32'(dut.state), 32'(ST_IDLE));
    sys_rst = 1'b0;
    repeat (20) step();
    chk("post_rst_idle", si_cnt, 4);

    // Counter wrap from a preloaded 0xFFFF.
    force dut.line_cnt_q = 16'hFFFF;
    step();
    release dut.line_cnt_q;
    chk("preload", 32'(line_cnt), 32'hFFFF);
    clear_mon();
    integ_cycles = '0;
    enable = 1'b1;
    wait_si(10, "wrap");
    t0 = cyc;
    enable = 1'b0;
    wait_done(1, 2000, "wrap");
    chk("wrap_line_cnt", 32'(line_cnt), 0);
    chk("wrap_done_time", done_cyc, t0 + 516);
    repeat (5) step();
    chk("done_single_pulse", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
